// File: rtl/clock_select_ctrl.sv
// Clock-switch sequencer: drains downstream logic, strobes a glitch-free
// clock selector, then waits for the selector's reset pulse to complete.
module clock_select_ctrl #(
    parameter int unsigned TIMEOUT        = 255,
    parameter logic        OUT_RST_ACTIVE = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ_VALID,
    input  logic REQ_SEL,
    output logic REQ_READY,
    output logic DRAIN_REQ,
    input  logic DRAIN_DONE,
    output logic SELECT,
    output logic SELECT_ENABLE,
    input  logic SEL_RST,
    output logic CUR_SEL,
    output logic DONE,
    output logic ERR
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LIM = CW'(LIM);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] DRAIN        = 3'd1;
    localparam logic [2:0] SWITCH       = 3'd2;
    localparam logic [2:0] WAIT_ASSERT  = 3'd3;
    localparam logic [2:0] WAIT_RELEASE = 3'd4;
    localparam logic [2:0] FINISH       = 3'd5;

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic          target;
    logic          select_q;
    logic          cur_sel_q;
    logic          err_q;
    logic [CW-1:0] cnt;
    logic [1:0]    sync;
    logic          rst_seen;
    logic          in_wait;
    logic          at_lim;
    logic          accept;
    logic          timeout;

    assign rst_seen = (sync[1] == OUT_RST_ACTIVE);
    assign in_wait  = (state == WAIT_ASSERT) || (state == WAIT_RELEASE);
    // Counter reaches TIMEOUT on the edge that ends a cycle spent at LIM or above.
    assign at_lim   = (cnt >= CNT_LIM);
    assign accept   = REQ_VALID && (state == IDLE);

    // A pending wait-state transition always takes priority over the timeout.
    assign timeout = at_lim &&
                     (((state == WAIT_ASSERT) && !rst_seen) ||
                      ((state == WAIT_RELEASE) && rst_seen));

    assign REQ_READY     = (state == IDLE) && !RST;
    assign DRAIN_REQ     = (state == DRAIN) || (state == SWITCH) || in_wait;
    assign SELECT_ENABLE = (state == SWITCH);
    assign SELECT        = select_q;
    assign CUR_SEL       = cur_sel_q;
    assign DONE          = (state == FINISH);
    assign ERR           = err_q;

    // Two-flop synchronizer for the selector's asynchronous reset output.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync <= {2{~OUT_RST_ACTIVE}};
        end else begin
            sync <= {sync[0], SEL_RST};
        end
    end

    // Next-state decode for the switch sequence.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    next_state = (REQ_SEL == cur_sel_q) ? FINISH : DRAIN;
                end
            end
            DRAIN: begin
                if (DRAIN_DONE) begin
                    next_state = SWITCH;
                end
            end
            SWITCH: begin
                next_state = WAIT_ASSERT;
            end
            WAIT_ASSERT: begin
                if (rst_seen) begin
                    next_state = WAIT_RELEASE;
                end else if (at_lim) begin
                    next_state = FINISH;
                end
            end
            WAIT_RELEASE: begin
                if (!rst_seen || at_lim) begin
                    next_state = FINISH;
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Target capture and selector drive; SELECT holds its last strobed value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            target   <= 1'b0;
            select_q <= 1'b0;
        end else begin
            if (accept) begin
                target <= REQ_SEL;
            end
            if ((state == DRAIN) && DRAIN_DONE) begin
                select_q <= target;
            end
        end
    end

    // Saturating wait counter, cleared as the sequence enters WAIT_ASSERT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (state == SWITCH) begin
            cnt <= '0;
        end else if (in_wait && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Sticky error flag and committed selection; an aborted switch keeps CUR_SEL.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q     <= 1'b0;
            cur_sel_q <= 1'b0;
        end else begin
            if (accept) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
            if ((state == FINISH) && !err_q) begin
                cur_sel_q <= target;
            end
        end
    end

endmodule

// File: doc/clock_select_ctrl.md
CLOCK_SELECT_CTRL -- requirements
Module: clock_select_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max CLK cycles spent awaiting the select-reset pulse before abort.
REQ-002 SHALL have parameter OUT_RST_ACTIVE, default 1'b0: active level of the select-reset input SEL_RST.
REQ-003 SHALL have port CLK  input  1  the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port REQ_VALID  input  1  switch request valid.
REQ-006 SHALL have port REQ_SEL  input  1  requested clock: 1 = A, 0 = B.
REQ-007 SHALL have port REQ_READY  output  1  request can be accepted.
REQ-008 SHALL have port DRAIN_REQ  output  1  asks downstream logic to quiesce.
REQ-009 SHALL have port DRAIN_DONE  input  1  downstream logic quiesced, synchronous to CLK.
REQ-010 SHALL have port SELECT  output  1  drives the clock selector's select input.
REQ-011 SHALL have port SELECT_ENABLE  output  1  one-cycle strobe loading SELECT into the selector.
REQ-012 SHALL have port SEL_RST  input  1  selector's output reset, asynchronous to CLK.
REQ-013 SHALL have port CUR_SEL  output  1  currently committed clock selection.
REQ-014 SHALL have port DONE  output  1  one-cycle pulse when a request completes or aborts.
REQ-015 SHALL have port ERR  output  1  sticky timeout flag.

Function
REQ-016 SEL_RST SHALL pass through a 2-flop synchronizer; "rst_seen" = synchronized value == OUT_RST_ACTIVE.
REQ-017 FSM states SHALL be IDLE, DRAIN, SWITCH, WAIT_ASSERT, WAIT_RELEASE, FINISH.
REQ-018 REQ_READY SHALL be 1 only in IDLE; accept = REQ_VALID & REQ_READY at a rising edge.
REQ-019 On accept, target register SHALL capture REQ_SEL and ERR SHALL clear.
REQ-020 On accept with REQ_SEL == CUR_SEL, FSM SHALL go to FINISH (no drain, no strobe).
REQ-021 On accept with REQ_SEL != CUR_SEL, FSM SHALL go to DRAIN; DRAIN_REQ = 1 from the next cycle.
REQ-022 DRAIN_REQ SHALL be 1 in DRAIN, SWITCH, WAIT_ASSERT, WAIT_RELEASE; 0 elsewhere.
REQ-023 DRAIN -> SWITCH when DRAIN_DONE = 1; DRAIN has no timeout.
REQ-024 In SWITCH, SELECT_ENABLE SHALL be 1 for exactly one cycle, SELECT = target; next state WAIT_ASSERT.
REQ-025 SELECT SHALL hold the last strobed value at all times, not only during the strobe.
REQ-026 WAIT_ASSERT -> WAIT_RELEASE when rst_seen = 1; WAIT_RELEASE -> FINISH when rst_seen = 0.
REQ-027 A timeout counter SHALL clear on entry to WAIT_ASSERT and increment each cycle in WAIT_ASSERT/WAIT_RELEASE, saturating at TIMEOUT.
REQ-028 Counter reaching TIMEOUT in either wait state SHALL set ERR, go to FINISH; CUR_SEL unchanged.
REQ-029 Timeout and transition condition in the same cycle: transition SHALL win, ERR stays 0.
REQ-030 In FINISH, DONE = 1 for one cycle; CUR_SEL <= target unless aborted; next state IDLE.
REQ-031 Latency, mismatched request, DRAIN_DONE already high: accept edge k, SELECT_ENABLE high in cycle k+2.
REQ-032 Latency, matching request: DONE high in cycle k+1, REQ_READY high again in cycle k+2.
REQ-033 REQ_VALID/REQ_SEL changes outside IDLE SHALL be ignored.

Reset
REQ-034 RST = 1 SHALL asynchronously force IDLE, SELECT = 0, SELECT_ENABLE = 0, CUR_SEL = 0, DONE = 0, ERR = 0, DRAIN_REQ = 0, counter = 0, synchronizer flops = ~OUT_RST_ACTIVE.
REQ-035 REQ_READY SHALL be 0 while RST = 1 and 1 from the first cycle after release.
REQ-036 RST mid-operation SHALL abort with no DONE pulse; CUR_SEL returns to 0, matching the selector's reset selection.

Verification
REQ-037 Reset, then REQ_SEL = 0 accepted -> DONE in next cycle, SELECT_ENABLE never asserted, CUR_SEL = 0.
REQ-038 REQ_SEL = 1, DRAIN_DONE held 0 for 10 cycles, then 1 -> one SELECT_ENABLE strobe with SELECT = 1, DRAIN_REQ high throughout.
REQ-039 After strobe, SEL_RST low 3 cycles then high -> DONE once after release, CUR_SEL = 1, DRAIN_REQ = 0, ERR = 0.
REQ-040 TIMEOUT = 8, SEL_RST never asserts -> ERR = 1 and DONE 8 cycles after WAIT_ASSERT entry, CUR_SEL unchanged; next accept clears ERR.
REQ-041 RST asserted during WAIT_RELEASE -> all outputs at reset values immediately, no DONE, REQ_READY = 1 after release.
REQ-042 REQ_VALID toggled with random REQ_SEL throughout busy periods -> no extra accepts; exactly one DONE per accept.
